shift_add_mult_n: RTL
=====================

# shift_add_mult_n

Parametrised sequential shift-add multiplier, successor to the fixed 16×16 `multiplier` block. It computes an N×N product one multiplier bit per clock, with an explicit start/busy/done handshake and a per-operation signed/unsigned mode. A compile-time option adds early termination. It sits in the arithmetic datapath wherever a low-area multi-cycle multiply is acceptable.

## Interface
- `WIDTH`, 16: operand width in bits. Minimum 2. Product width is 2·WIDTH.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous reset, active-high.
- `start` input 1: request a new operation. Sampled only in IDLE or DONE.
- `is_signed` input 1: 1 = two's-complement operands, 0 = unsigned. Sampled with `start`.
- `A` input WIDTH: multiplicand. Sampled with `start`.
- `B` input WIDTH: multiplier. Sampled with `start`.
- `Q` output 2·WIDTH: product. Valid from `done` until the next accepted `start`.
- `busy` output 1: high while an operation is in progress (RUN).
- `done` output 1: single-cycle pulse when `Q` updates.

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with `start`=1 → load, enter RUN. `start` in RUN is ignored.
- Load:
  - Unsigned mode: latch |A|=A, |B|=B.
  - Signed mode: latch magnitudes and `neg` = A[W-1] XOR B[W-1].
  - Clear the 2·WIDTH accumulator and the bit counter.
- RUN, per cycle:
  - If the multiplier LSB is 1, add the shifted multiplicand into the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Increment the counter.
- RUN → DONE after WIDTH cycles.
  - On this edge, `Q` ← accumulator, or its two's-complement negation when `neg`=1.
  - `done`=1 for that DONE cycle.
- DONE with `start`=0 → IDLE. `Q` holds.
- Width rules:
  - Magnitude of −2^(W-1) is 2^(W-1), which fits in W unsigned bits.
  - The worst signed case, (−2^(W-1))², is 2^(2W-2) and fits in 2·WIDTH.
  - No overflow in any mode.
- Reset values: `Q`=0, `busy`=0, `done`=0, state IDLE. `rst` has priority over `start`.

## Timing
- `start` accepted at edge 0 → `busy`=1 from edge 0 to edge WIDTH → `done`=1 and `Q` valid after edge WIDTH+1 (default: 17 cycles).
- Back-to-back: `start` held high during DONE launches the next operation on the following edge. There is no idle bubble; `done` still pulses exactly once per operation.
- `start` held high continuously: operations repeat every WIDTH+1 cycles.
- `rst` mid-RUN: the next edge returns to IDLE with all outputs 0. The partial result is discarded and no `done` pulse is issued.
- Operands and `is_signed` changing during RUN have no effect.

## Configuration
- `MUL_EARLY_TERM_EN` defined:
  - RUN exits once the remaining (shifted) multiplier is zero.
  - RUN length = max(1, index of the highest set bit of |B| + 1).
  - `done` follows at RUN length + 1 cycles after `start`.
  - B=0 gives a latency of 2.
- `MUL_EARLY_TERM_EN` undefined: fixed WIDTH RUN cycles regardless of operands.
- Results are identical in both builds.

## Structure
- Shared package `mult_pkg`:
  - State encoding (IDLE/RUN/DONE).
  - Counter width function, clog2(WIDTH+1).
- Sub-module `mult_abs_neg`: combinational conditional two's-complement (magnitude at load, negation at DONE), parametrised by width. Instantiated twice at WIDTH and once at 2·WIDTH.

## Test plan
- Reset/idle: hold `rst` 3 cycles → `Q`=0, `busy`=0, `done`=0. Assert `start` together with `rst` → no operation starts.
- Unsigned, WIDTH=16: A=0x0032, B=0x067F, `is_signed`=0 → `Q`=0x000144CE, `done` exactly 17 cycles after `start`. A=0x00FF, B=0x0101 → `Q`=0x0000FFFF.
- Signed corners:
  - A=0xFFFD (−3), B=0x0005 → `Q`=0xFFFFFFF1.
  - A=B=0x8000 → `Q`=0x40000000.
  - The same 0x8000 operands with `is_signed`=0 → `Q`=0x40000000.
- Back-to-back and ignore-while-busy:
  - Hold `start` high across three operations → three single-cycle `done` pulses, 17 cycles apart, each with the correct `Q`.
  - Toggle A/B mid-RUN → result unaffected.
- Reset mid-operation: assert `rst` at cycle 8 of RUN → next cycle IDLE, `Q`=0, no `done`. A fresh `start` afterwards yields the correct product.
- Early termination (build with `MUL_EARLY_TERM_EN`):
  - B=0x0003, A=0x1234 → `Q`=0x0000369C, `done` 3 cycles after `start`.
  - B=0 → `Q`=0, latency 2.
  - Without the macro, both cases give latency 17.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier family: FSM state encoding
// and the bit-counter width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_t;

    // Counter must be able to hold values 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_abs_neg.sv
// Conditional two's-complement: passes din through, or negates it when en=1.
// Used for operand magnitudes at load and for the result sign fix-up.
module mult_abs_neg #(
    parameter int W = 16
) (
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    always_comb begin
        dout = en ? -din : din;
    end

endmodule

// File: rtl/shift_add_mult_n.sv
// Sequential WIDTH x WIDTH shift-add multiplier with start/busy/done handshake
// and per-operation signed mode. Define MUL_EARLY_TERM_EN for early termination.
module shift_add_mult_n
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Q,
    output logic                 busy,
    output logic                 done
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);

    mult_state_t     state, state_nx;
    logic [PW-1:0]   mcd, mcd_nx;
    logic [PW-1:0]   acc, acc_nx;
    logic [PW-1:0]   acc_sum, acc_fix;
    logic [PW-1:0]   q_nx;
    logic [WIDTH-1:0] mlr, mlr_nx;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            neg, neg_nx;
    logic            last;

    mult_abs_neg #(.W(WIDTH)) u_abs_a (
        .en   (is_signed & A[WIDTH-1]),
        .din  (A),
        .dout (a_mag)
    );

    mult_abs_neg #(.W(WIDTH)) u_abs_b (
        .en   (is_signed & B[WIDTH-1]),
        .din  (B),
        .dout (b_mag)
    );

    // Sign fix-up works on the post-add sum so the final iteration and the
    // result write share one edge.
    mult_abs_neg #(.W(PW)) u_fix (
        .en   (neg),
        .din  (acc_sum),
        .dout (acc_fix)
    );

    always_comb begin
        state_nx = state;
        mcd_nx   = mcd;
        mlr_nx   = mlr;
        acc_nx   = acc;
        cnt_nx   = cnt;
        neg_nx   = neg;
        q_nx     = Q;
        acc_sum  = acc + (mlr[0] ? mcd : '0);
`ifdef MUL_EARLY_TERM_EN
        last     = ((mlr >> 1) == '0) || (cnt == CW'(WIDTH - 1));
`else
        last     = (cnt == CW'(WIDTH - 1));
`endif

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nx = ST_RUN;
                    mcd_nx   = {{WIDTH{1'b0}}, a_mag};
                    mlr_nx   = b_mag;
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    neg_nx   = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_nx = acc_sum;
                mcd_nx = mcd << 1;
                mlr_nx = mlr >> 1;
                cnt_nx = cnt + CW'(1);
                if (last) begin
                    state_nx = ST_DONE;
                    q_nx     = acc_fix;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            mcd   <= '0;
            mlr   <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            Q     <= '0;
        end else begin
            state <= state_nx;
            mcd   <= mcd_nx;
            mlr   <= mlr_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            neg   <= neg_nx;
            Q     <= q_nx;
        end
    end

    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

endmodule
